// File: rtl/ps2_mouse_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_mouse_tracker_if
// Byte-level link between the mouse tracker and the ps2rx/ps2tx engines.
//   rx_data  : byte received from the device (ps2rx)
//   rx_valid : one-cycle strobe, rx_data valid
//   tx_done  : one-cycle strobe from ps2tx, requested byte has been sent
//   tx_req   : request ps2tx to send tx_data
//   tx_data  : command byte to send
// master = tracker side, slave = byte-engine side.
// ---------------------------------------------------------------------------
interface ps2_mouse_tracker_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic       tx_req;
  logic [7:0] tx_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_done,
    output tx_req,
    output tx_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_done,
    input  tx_req,
    input  tx_data
  );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// ps2_mouse_tracker
// PS/2 mouse host controller and cursor tracker. Walks the device init
// command table (optionally negotiating IntelliMouse wheel mode), then
// decodes stream packets into a screen-clamped cursor, button state and a
// wrapping wheel accumulator.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : ps2rx/ps2tx byte link (master modport)
//   cursor_x/y  : cursor position, y = 0 at top of screen
//   buttons     : {middle, right, left}
//   wheel_acc   : signed running wheel sum, wraps modulo 256
//   pkt_valid   : one-cycle strobe when a packet has been applied
//   streaming   : init finished, packets are being decoded
//   wheel_mode  : 4-byte IntelliMouse packets active
//   err_cnt     : saturating protocol error count
// ---------------------------------------------------------------------------
module ps2_mouse_tracker #(
  parameter int CW           = 10,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int X_INIT       = 100,
  parameter int Y_INIT       = 100,
  parameter int WHEEL_EN     = 1,
  parameter int RESP_TIMEOUT = 2_500_000,
  parameter int BYTE_TIMEOUT = 250_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ps2_mouse_tracker_if.master    bus,
  output logic [CW-1:0]          cursor_x,
  output logic [CW-1:0]          cursor_y,
  output logic [2:0]             buttons,
  output logic [7:0]             wheel_acc,
  output logic                   pkt_valid,
  output logic                   streaming,
  output logic                   wheel_mode,
  output logic [7:0]             err_cnt
);

  localparam int TMAX = (RESP_TIMEOUT > BYTE_TIMEOUT) ? RESP_TIMEOUT : BYTE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic signed [CW+1:0] X_MAX = (CW+2)'(SCREEN_W - 1);
  localparam logic signed [CW+1:0] Y_MAX = (CW+2)'(SCREEN_H - 1);

  localparam logic [1:0] K_SEND    = 2'd0;
  localparam logic [1:0] K_EXPECT  = 2'd1;
  localparam logic [1:0] K_READ_ID = 2'd2;
  localparam logic [1:0] K_DONE    = 2'd3;

  typedef enum logic [2:0] {
    S_INIT_TX, S_INIT_WAIT_TX, S_INIT_RX, S_B0, S_B1, S_B2, S_B3, S_APPLY
  } state_t;

  state_t          state;
  logic [4:0]      idx;
  logic [TW-1:0]   timer;
  logic [6:0]      hdr;      // {yovf, xovf, ysign, xsign, btn[2:0]}; sync bit 3 not kept
  logic [7:0]      b1_q;
  logic [7:0]      b2_q;
  logic [3:0]      wnib;

  logic [9:0]      step;
  logic [1:0]      step_kind;
  logic [7:0]      step_byte;
  logic signed [CW+1:0] dx, dy, sum_x, sum_y;
  logic [CW-1:0]   new_x, new_y;
  logic            init_err, sync_err;

  // Init command table: {kind, byte}. Indices past the end read as DONE.
  function automatic logic [9:0] step_of(input logic [4:0] i);
    logic [9:0] s;
    s = {K_DONE, 8'h00};
    if (WHEEL_EN != 0) begin
      case (i)
        5'd0:  s = {K_SEND,    8'hFF};
        5'd1:  s = {K_EXPECT,  8'hFA};
        5'd2:  s = {K_EXPECT,  8'hAA};
        5'd3:  s = {K_EXPECT,  8'h00};
        5'd4:  s = {K_SEND,    8'hF3};
        5'd5:  s = {K_EXPECT,  8'hFA};
        5'd6:  s = {K_SEND,    8'hC8};
        5'd7:  s = {K_EXPECT,  8'hFA};
        5'd8:  s = {K_SEND,    8'hF3};
        5'd9:  s = {K_EXPECT,  8'hFA};
        5'd10: s = {K_SEND,    8'h64};
        5'd11: s = {K_EXPECT,  8'hFA};
        5'd12: s = {K_SEND,    8'hF3};
        5'd13: s = {K_EXPECT,  8'hFA};
        5'd14: s = {K_SEND,    8'h50};
        5'd15: s = {K_EXPECT,  8'hFA};
        5'd16: s = {K_SEND,    8'hF2};
        5'd17: s = {K_EXPECT,  8'hFA};
        5'd18: s = {K_READ_ID, 8'h00};
        5'd19: s = {K_SEND,    8'hF4};
        5'd20: s = {K_EXPECT,  8'hFA};
        default: s = {K_DONE,  8'h00};
      endcase
    end else begin
      case (i)
        5'd0:  s = {K_SEND,    8'hFF};
        5'd1:  s = {K_EXPECT,  8'hFA};
        5'd2:  s = {K_EXPECT,  8'hAA};
        5'd3:  s = {K_EXPECT,  8'h00};
        5'd4:  s = {K_SEND,    8'hF4};
        5'd5:  s = {K_EXPECT,  8'hFA};
        default: s = {K_DONE,  8'h00};
      endcase
    end
    return s;
  endfunction

  // Movement is computed two bits wider than the cursor so both underflow
  // below 0 and overshoot past the screen edge are visible before clamping.
  always_comb begin
    step      = step_of(idx);
    step_kind = step[9:8];
    step_byte = step[7:0];

    dx    = hdr[5] ? '0 : {{(CW-7){hdr[3]}}, hdr[3], b1_q};
    dy    = hdr[6] ? '0 : {{(CW-7){hdr[4]}}, hdr[4], b2_q};
    sum_x = $signed({2'b00, cursor_x}) + dx;
    sum_y = $signed({2'b00, cursor_y}) - dy;

    if (sum_x[CW+1])       new_x = '0;
    else if (sum_x > X_MAX) new_x = X_MAX[CW-1:0];
    else                    new_x = sum_x[CW-1:0];

    if (sum_y[CW+1])       new_y = '0;
    else if (sum_y > Y_MAX) new_y = Y_MAX[CW-1:0];
    else                    new_y = sum_y[CW-1:0];

    init_err = (state == S_INIT_RX) &&
               (bus.rx_valid ? (step_kind == K_EXPECT && bus.rx_data != step_byte)
                             : (timer == RESP_LAST));
    sync_err = (state == S_B0 || state == S_APPLY) && bus.rx_valid && !bus.rx_data[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT_TX;
      idx         <= '0;
      timer       <= '0;
      hdr         <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      wnib        <= '0;
      cursor_x    <= CW'(X_INIT);
      cursor_y    <= CW'(Y_INIT);
      buttons     <= '0;
      wheel_acc   <= '0;
      pkt_valid   <= 1'b0;
      streaming   <= 1'b0;
      wheel_mode  <= 1'b0;
      err_cnt     <= '0;
      bus.tx_req  <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      pkt_valid <= 1'b0;

      if ((init_err || sync_err) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      case (state)
        S_INIT_TX: begin
          timer <= '0;
          case (step_kind)
            K_SEND: begin
              bus.tx_req  <= 1'b1;
              bus.tx_data <= step_byte;
              state       <= S_INIT_WAIT_TX;
            end
            K_EXPECT, K_READ_ID: state <= S_INIT_RX;
            default: begin
              streaming <= 1'b1;
              state     <= S_B0;
            end
          endcase
        end

        // Bytes arriving while a command is in flight are deliberately ignored.
        S_INIT_WAIT_TX: begin
          if (bus.tx_done) begin
            bus.tx_req <= 1'b0;
            idx        <= idx + 5'd1;
            state      <= S_INIT_TX;
          end
        end

        // Any failure restarts the whole table; cursor state is kept.
        S_INIT_RX: begin
          if (init_err) begin
            idx        <= '0;
            streaming  <= 1'b0;
            wheel_mode <= 1'b0;
            state      <= S_INIT_TX;
          end else if (bus.rx_valid) begin
            if (step_kind == K_READ_ID)
              wheel_mode <= (bus.rx_data == 8'h03);
            idx   <= idx + 5'd1;
            state <= S_INIT_TX;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // APPLY also behaves as B0 so a header arriving in that cycle is kept.
        S_B0, S_APPLY: begin
          if (state == S_APPLY) begin
            buttons   <= hdr[2:0];
            cursor_x  <= new_x;
            cursor_y  <= new_y;
            pkt_valid <= 1'b1;
            if (wheel_mode)
              wheel_acc <= wheel_acc + {{4{wnib[3]}}, wnib};
          end
          timer <= '0;
          if (bus.rx_valid && bus.rx_data[3]) begin
            hdr   <= {bus.rx_data[7:4], bus.rx_data[2:0]};
            state <= S_B1;
          end else begin
            state <= S_B0;
          end
        end

        S_B1, S_B2, S_B3: begin
          if (bus.rx_valid) begin
            timer <= '0;
            case (state)
              S_B1: begin
                b1_q  <= bus.rx_data;
                state <= S_B2;
              end
              S_B2: begin
                b2_q  <= bus.rx_data;
                state <= wheel_mode ? S_B3 : S_APPLY;
              end
              default: begin
                wnib  <= bus.rx_data[3:0];
                state <= S_APPLY;
              end
            endcase
          end else if (timer == BYTE_LAST) begin
            state <= S_B0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= S_INIT_TX;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_tracker
// Directed bench for ps2_mouse_tracker. Instance A has the wheel disabled
// and exercises 3-byte packets, clamping, overflow and resync; instance B
// has the wheel enabled and exercises init errors, the ID handshake and
// 4-byte packets. Timeouts are shortened so the run stays small.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_tracker;

  localparam int RESP_TO = 40;
  localparam int BYTE_TO = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ps2_mouse_tracker_if bus_a ();
  ps2_mouse_tracker_if bus_b ();

  logic [9:0] a_cursor_x, a_cursor_y, b_cursor_x, b_cursor_y;
  logic [2:0] a_buttons, b_buttons;
  logic [7:0] a_wheel_acc, b_wheel_acc, a_err_cnt, b_err_cnt;
  logic       a_pkt_valid, b_pkt_valid, a_streaming, b_streaming;
  logic       a_wheel_mode, b_wheel_mode;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int a_pkt_cnt  = 0;
  int b_pkt_cnt  = 0;

  ps2_mouse_tracker #(
    .WHEEL_EN(0), .RESP_TIMEOUT(RESP_TO), .BYTE_TIMEOUT(BYTE_TO)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .cursor_x(a_cursor_x), .cursor_y(a_cursor_y), .buttons(a_buttons),
    .wheel_acc(a_wheel_acc), .pkt_valid(a_pkt_valid), .streaming(a_streaming),
    .wheel_mode(a_wheel_mode), .err_cnt(a_err_cnt)
  );

  ps2_mouse_tracker #(
    .WHEEL_EN(1), .RESP_TIMEOUT(RESP_TO), .BYTE_TIMEOUT(BYTE_TO)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .cursor_x(b_cursor_x), .cursor_y(b_cursor_y), .buttons(b_buttons),
    .wheel_acc(b_wheel_acc), .pkt_valid(b_pkt_valid), .streaming(b_streaming),
    .wheel_mode(b_wheel_mode), .err_cnt(b_err_cnt)
  );

  // Count strobe cycles mid-period, away from the active edge.
  always @(negedge clk) begin
    if (a_pkt_valid) a_pkt_cnt++;
    if (b_pkt_valid) b_pkt_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle rx_valid pulse carrying byte b to instance sel.
  task automatic apply_stimulus(input bit sel, input logic [7:0] b);
    @(posedge clk);
    #1;
    if (sel) begin bus_b.rx_data = b; bus_b.rx_valid = 1'b1; end
    else     begin bus_a.rx_data = b; bus_a.rx_valid = 1'b1; end
    @(posedge clk);
    #1;
    if (sel) bus_b.rx_valid = 1'b0;
    else     bus_a.rx_valid = 1'b0;
  endtask

  // Wait (bounded) for a send request, check the byte, hold it, acknowledge.
  task automatic expect_tx(input bit sel, input logic [7:0] exp, input string tag);
    int  waited;
    bit  got;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 200) begin
      if (sel ? bus_b.tx_req : bus_a.tx_req) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    check_output({tag, "_req"}, 32'(got), 32'd1);
    if (got) begin
      check_output({tag, "_data"}, 32'(sel ? bus_b.tx_data : bus_a.tx_data), 32'(exp));
      idle(2);
      check_output({tag, "_hold"}, 32'(sel ? {bus_b.tx_req, bus_b.tx_data} : {bus_a.tx_req, bus_a.tx_data}),
                   32'({1'b1, exp}));
      if (sel) bus_b.tx_done = 1'b1; else bus_a.tx_done = 1'b1;
      @(posedge clk);
      #1;
      if (sel) bus_b.tx_done = 1'b0; else bus_a.tx_done = 1'b0;
      check_output({tag, "_drop"}, 32'(sel ? bus_b.tx_req : bus_a.tx_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rate_seq [6];
    rate_seq = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50};

    rst_n = 1'b0;
    bus_a.rx_data = '0; bus_a.rx_valid = 1'b0; bus_a.tx_done = 1'b0;
    bus_b.rx_data = '0; bus_b.rx_valid = 1'b0; bus_b.tx_done = 1'b0;
    #12;
    check_output("rst_x", 32'(a_cursor_x), 32'd100);
    check_output("rst_y", 32'(a_cursor_y), 32'd100);
    check_output("rst_btn", 32'(a_buttons), 32'd0);
    check_output("rst_wheel", 32'(b_wheel_acc), 32'd0);
    check_output("rst_flags", 32'({a_streaming, b_wheel_mode, a_pkt_valid, bus_a.tx_req, bus_b.tx_req}), 32'd0);
    check_output("rst_err", 32'(a_err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- Instance A: 3-byte init ----
    $display("[TB] instance A init");
    expect_tx(1'b0, 8'hFF, "a_tx_ff");
    apply_stimulus(1'b0, 8'hFA);
    apply_stimulus(1'b0, 8'hAA);
    apply_stimulus(1'b0, 8'h00);
    expect_tx(1'b0, 8'hF4, "a_tx_f4");
    apply_stimulus(1'b0, 8'hFA);
    idle(3);
    check_output("a_streaming", 32'(a_streaming), 32'd1);
    check_output("a_wheel_mode", 32'(a_wheel_mode), 32'd0);
    check_output("a_init_err", 32'(a_err_cnt), 32'd0);
    idle(5);
    check_output("a_no_more_tx", 32'(bus_a.tx_req), 32'd0);

    // ---- Instance A: packets ----
    apply_stimulus(1'b0, 8'h09); apply_stimulus(1'b0, 8'h05); apply_stimulus(1'b0, 8'h03);
    idle(1);
    check_output("a_p1_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd105, 10'd97}));
    check_output("a_p1_btn", 32'(a_buttons), 32'd1);
    check_output("a_p1_pv_hi", 32'(a_pkt_valid), 32'd1);
    idle(1);
    check_output("a_p1_pv_lo", 32'(a_pkt_valid), 32'd0);

    apply_stimulus(1'b0, 8'h38); apply_stimulus(1'b0, 8'hF6); apply_stimulus(1'b0, 8'hFE);
    idle(1);
    check_output("a_p2_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd95, 10'd99}));
    check_output("a_p2_btn", 32'(a_buttons), 32'd0);

    apply_stimulus(1'b0, 8'h38); apply_stimulus(1'b0, 8'hA3); apply_stimulus(1'b0, 8'h00);
    idle(1);
    check_output("a_p3_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd2, 10'd355}));
    apply_stimulus(1'b0, 8'h28); apply_stimulus(1'b0, 8'h00); apply_stimulus(1'b0, 8'h85);
    idle(1);
    check_output("a_p4_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd2, 10'd478}));

    apply_stimulus(1'b0, 8'h38); apply_stimulus(1'b0, 8'hF0); apply_stimulus(1'b0, 8'h80);
    idle(1);
    check_output("a_clamp_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd0, 10'd479}));

    apply_stimulus(1'b0, 8'h48); apply_stimulus(1'b0, 8'h7F); apply_stimulus(1'b0, 8'h00);
    idle(1);
    check_output("a_xovf_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd0, 10'd479}));
    idle(1);
    check_output("a_pkt_cnt6", 32'(a_pkt_cnt), 32'd6);

    // ---- Instance A: resync ----
    apply_stimulus(1'b0, 8'h00);
    idle(2);
    check_output("a_sync_err", 32'(a_err_cnt), 32'd1);
    apply_stimulus(1'b0, 8'h08); apply_stimulus(1'b0, 8'h05);
    idle(BYTE_TO + 5);
    check_output("a_timeout_nopkt", 32'(a_pkt_cnt), 32'd6);
    apply_stimulus(1'b0, 8'h08); apply_stimulus(1'b0, 8'h01); apply_stimulus(1'b0, 8'h00);
    idle(1);
    check_output("a_resync_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd1, 10'd479}));
    idle(1);
    check_output("a_pkt_cnt7", 32'(a_pkt_cnt), 32'd7);
    check_output("a_resync_err", 32'(a_err_cnt), 32'd1);

    // ---- Instance B: init errors ----
    $display("[TB] instance B init");
    expect_tx(1'b1, 8'hFF, "b_tx_ff0");
    apply_stimulus(1'b1, 8'hFA);
    apply_stimulus(1'b1, 8'hFC);
    idle(1);
    check_output("b_bad_err", 32'(b_err_cnt), 32'd1);
    check_output("b_bad_stream", 32'(b_streaming), 32'd0);
    check_output("b_bad_xy", 32'({b_cursor_x, b_cursor_y}), 32'({10'd100, 10'd100}));
    expect_tx(1'b1, 8'hFF, "b_tx_ff1");
    idle(RESP_TO + 5);
    check_output("b_resp_timeout", 32'(b_err_cnt), 32'd2);
    expect_tx(1'b1, 8'hFF, "b_tx_ff2");

    // ---- Instance B: full wheel negotiation ----
    apply_stimulus(1'b1, 8'hFA);
    apply_stimulus(1'b1, 8'hAA);
    apply_stimulus(1'b1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      expect_tx(1'b1, rate_seq[i], $sformatf("b_tx_rate%0d", i));
      apply_stimulus(1'b1, 8'hFA);
    end
    expect_tx(1'b1, 8'hF2, "b_tx_f2");
    apply_stimulus(1'b1, 8'hFA);
    apply_stimulus(1'b1, 8'h03);
    expect_tx(1'b1, 8'hF4, "b_tx_f4");
    apply_stimulus(1'b1, 8'hFA);
    idle(3);
    check_output("b_streaming", 32'(b_streaming), 32'd1);
    check_output("b_wheel_mode", 32'(b_wheel_mode), 32'd1);
    check_output("b_init_err", 32'(b_err_cnt), 32'd2);

    // ---- Instance B: 4-byte packets ----
    apply_stimulus(1'b1, 8'h08); apply_stimulus(1'b1, 8'h00);
    apply_stimulus(1'b1, 8'h00); apply_stimulus(1'b1, 8'hFF);
    idle(1);
    check_output("b_wheel_m1", 32'(b_wheel_acc), 32'hFF);
    check_output("b_pv_hi", 32'(b_pkt_valid), 32'd1);
    check_output("b_xy", 32'({b_cursor_x, b_cursor_y}), 32'({10'd100, 10'd100}));
    idle(1);
    check_output("b_pv_lo", 32'(b_pkt_valid), 32'd0);
    check_output("b_pkt_cnt1", 32'(b_pkt_cnt), 32'd1);
    apply_stimulus(1'b1, 8'h08); apply_stimulus(1'b1, 8'h00);
    apply_stimulus(1'b1, 8'h00); apply_stimulus(1'b1, 8'h02);
    idle(1);
    check_output("b_wheel_wrap", 32'(b_wheel_acc), 32'h01);

    // ---- Reset mid-packet ----
    apply_stimulus(1'b0, 8'h09);
    rst_n = 1'b0;
    #3;
    check_output("midrst_xy", 32'({a_cursor_x, a_cursor_y}), 32'({10'd100, 10'd100}));
    check_output("midrst_flags", 32'({a_streaming, b_streaming, b_wheel_mode}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_tx(1'b0, 8'hFF, "a_tx_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
